// File: rtl/piece_queue_pkg.sv
// Shared definitions for the piece preview queue: piece codes, FSM state
// encoding and a sizing helper used by the queue and its storage.
package piece_queue_pkg;

   typedef enum logic [2:0] {
      PIECE_NONE = 3'd0,
      I_BLOCK    = 3'd1,
      O_BLOCK    = 3'd2,
      T_BLOCK    = 3'd3,
      S_BLOCK    = 3'd4,
      Z_BLOCK    = 3'd5,
      J_BLOCK    = 3'd6,
      L_BLOCK    = 3'd7
   } piece_e;

   typedef enum logic [1:0] {
      ST_FETCH_REQ  = 2'd0,
      ST_FETCH_WAIT = 2'd1,
      ST_FETCH_CAP  = 2'd2,
      ST_READY      = 2'd3
   } state_e;

   // Width of an occupancy counter that must reach DEPTH itself.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/piece_queue_if.sv
// Game-FSM side of the piece queue: spawn/hold handshake, hold slot and preview.
interface piece_queue_if #(
   parameter int DEPTH   = 3,
   parameter int PIECE_W = 3
);
   logic                       spawn_req;
   logic                       hold_req;
   logic [PIECE_W-1:0]         active_piece;
   logic                       ready;
   logic                       spawn_ack;
   logic [PIECE_W-1:0]         spawn_piece;
   logic [PIECE_W-1:0]         hold_piece;
   logic                       hold_used;
   logic [DEPTH*PIECE_W-1:0]   preview;

   modport master (
      output spawn_req, hold_req, active_piece,
      input  ready, spawn_ack, spawn_piece, hold_piece, hold_used, preview
   );

   modport slave (
      input  spawn_req, hold_req, active_piece,
      output ready, spawn_ack, spawn_piece, hold_piece, hold_used, preview
   );
endinterface

// File: rtl/piece_queue_shift.sv
// DEPTH-slot preview storage: push lands at the current count, pop removes
// the head and shifts everything one slot toward it.
module piece_shift_queue
   import piece_queue_pkg::*;
#(
   parameter  int DEPTH   = 3,
   parameter  int PIECE_W = 3,
   localparam int CNT_W   = count_width(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [PIECE_W-1:0]       push_data,
   input  logic                     pop,
   output logic [DEPTH*PIECE_W-1:0] slots,
   output logic [CNT_W-1:0]         count
);

   logic [PIECE_W-1:0] slot_r [DEPTH];
   logic [CNT_W-1:0]   count_r;

   // Slot storage and occupancy; pop has priority over push.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_r[i] <= {PIECE_W{1'b0}};
         end
         count_r <= {CNT_W{1'b0}};
      end else if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            slot_r[i] <= slot_r[i+1];
         end
         slot_r[DEPTH-1] <= {PIECE_W{1'b0}};
         if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
         end
      end else if (push && (count_r < CNT_W'(DEPTH))) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (count_r == CNT_W'(i)) begin
               slot_r[i] <= push_data;
            end
         end
         count_r <= count_r + CNT_W'(1);
      end
   end

   // Flatten the slots, head in the low bits.
   always_comb begin
      slots = {(DEPTH*PIECE_W){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         slots[i*PIECE_W +: PIECE_W] = slot_r[i];
      end
   end

   assign count = count_r;

endmodule

// File: rtl/piece_queue.sv
// Preview queue between the tetromino randomizer and the game FSM: refills one
// piece per 3-cycle fetch, serves spawns and implements the once-per-piece hold.
module piece_queue
   import piece_queue_pkg::*;
#(
   parameter int DEPTH   = 3,
   parameter int PIECE_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIECE_W-1:0] rand_piece,
   output logic               rand_req,
   piece_queue_if.slave       game
);

   localparam int                 CNT_W      = count_width(DEPTH);
   localparam logic [PIECE_W-1:0] EMPTY_CODE = {PIECE_W{1'b0}};

   state_e                   state_r;
   logic                     rand_req_r;
   logic                     ready_r;
   logic                     spawn_ack_r;
   logic                     hold_used_r;
   logic [PIECE_W-1:0]       spawn_piece_r;
   logic [PIECE_W-1:0]       hold_piece_r;

   logic [DEPTH*PIECE_W-1:0] slots_s;
   logic [CNT_W-1:0]         count_s;
   logic [PIECE_W-1:0]       head_s;
   logic                     accept_s;
   logic                     spawn_go_s;
   logic                     hold_go_s;
   logic                     hold_empty_s;
   logic                     pop_s;
   logic                     push_s;

   assign head_s = slots_s[PIECE_W-1:0];

   // Request acceptance needs ready visible and no ack in flight, so acks never
   // come back to back.
   always_comb begin
      accept_s     = (state_r == ST_READY) && ready_r && !spawn_ack_r;
      spawn_go_s   = accept_s && game.spawn_req;
      hold_go_s    = accept_s && !game.spawn_req && game.hold_req && !hold_used_r;
      hold_empty_s = (hold_piece_r == EMPTY_CODE);
      pop_s        = spawn_go_s || (hold_go_s && hold_empty_s);
      push_s       = (state_r == ST_FETCH_CAP) && (rand_piece != EMPTY_CODE);
   end

   piece_shift_queue #(
      .DEPTH   (DEPTH),
      .PIECE_W (PIECE_W)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (rand_piece),
      .pop       (pop_s),
      .slots     (slots_s),
      .count     (count_s)
   );

   // Fetch/serve FSM with registered strobe, handshake and hold-slot outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_FETCH_REQ;
         rand_req_r    <= 1'b0;
         ready_r       <= 1'b0;
         spawn_ack_r   <= 1'b0;
         hold_used_r   <= 1'b0;
         spawn_piece_r <= EMPTY_CODE;
         hold_piece_r  <= EMPTY_CODE;
      end else begin
         rand_req_r  <= 1'b0;
         spawn_ack_r <= 1'b0;
         ready_r     <= (state_r == ST_READY);
         case (state_r)
            ST_FETCH_REQ: begin
               rand_req_r <= 1'b1;
               state_r    <= ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
               state_r <= ST_FETCH_CAP;
            end
            ST_FETCH_CAP: begin
               // A zero from the randomizer is dropped and simply re-fetched.
               if (push_s && (count_s == CNT_W'(DEPTH - 1))) begin
                  state_r <= ST_READY;
               end else begin
                  state_r <= ST_FETCH_REQ;
               end
            end
            ST_READY: begin
               if (spawn_go_s) begin
                  spawn_piece_r <= head_s;
                  spawn_ack_r   <= 1'b1;
                  hold_used_r   <= 1'b0;
                  state_r       <= ST_FETCH_REQ;
               end else if (hold_go_s) begin
                  spawn_ack_r  <= 1'b1;
                  hold_used_r  <= 1'b1;
                  hold_piece_r <= game.active_piece;
                  if (hold_empty_s) begin
                     spawn_piece_r <= head_s;
                     state_r       <= ST_FETCH_REQ;
                  end else begin
                     spawn_piece_r <= hold_piece_r;
                  end
               end
            end
            default: begin
               state_r <= ST_FETCH_REQ;
            end
         endcase
      end
   end

   assign rand_req         = rand_req_r;
   assign game.ready       = ready_r;
   assign game.spawn_ack   = spawn_ack_r;
   assign game.spawn_piece = spawn_piece_r;
   assign game.hold_piece  = hold_piece_r;
   assign game.hold_used   = hold_used_r;
   assign game.preview     = slots_s;

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: directed scenarios with literal
// expectations, then randomized spawn/hold traffic against a queue-level model.
module tb_piece_queue;
   import piece_queue_pkg::*;

   localparam int DEPTH = 3;
   localparam int PW    = 3;

   logic          clk        = 1'b0;
   logic          rst        = 1'b1;
   logic [PW-1:0] rand_piece = '0;
   logic          rand_req;

   piece_queue_if #(.DEPTH(DEPTH), .PIECE_W(PW)) game_if ();

   piece_queue #(.DEPTH(DEPTH), .PIECE_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .rand_piece (rand_piece),
      .rand_req   (rand_req),
      .game       (game_if)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Stub randomizer: advances on each strobe, scripted values first.
   logic [PW-1:0] seq [$];
   always @(posedge clk) begin
      if (rand_req === 1'b1) begin
         if (seq.size() > 0) rand_piece <= seq.pop_front();
         else                rand_piece <= PW'($urandom_range(0, 7));
      end
   end

   // Reference model: the preview is a plain queue; a refill is one fetch every
   // three cycles while the queue is short; ready trails "queue full" by a cycle.
   logic [PW-1:0] m_q [$];
   logic [PW-1:0] m_hold, m_spawn;
   bit            m_hused, m_ack, m_rreq, m_ready, m_started;
   int            m_phase;

   always @(posedge clk) begin : model
      bit was_full, take;
      m_started = 1'b1;
      if (rst) begin
         m_q.delete();
         m_hold = '0; m_spawn = '0;
         m_hused = 1'b0; m_ack = 1'b0; m_rreq = 1'b0; m_ready = 1'b0;
         m_phase = 0;
      end else begin
         was_full = (m_q.size() == DEPTH);
         take     = was_full && m_ready && !m_ack;
         m_ready  = was_full;
         m_rreq   = 1'b0;
         m_ack    = 1'b0;
         if (!was_full) begin
            if (m_phase == 0) begin
               m_rreq  = 1'b1;
               m_phase = 1;
            end else if (m_phase == 1) begin
               m_phase = 2;
            end else begin
               if (rand_piece != '0) m_q.push_back(rand_piece);
               m_phase = 0;
            end
         end else if (take && game_if.spawn_req) begin
            m_spawn = m_q.pop_front();
            m_ack   = 1'b1;
            m_hused = 1'b0;
            m_phase = 0;
         end else if (take && game_if.hold_req && !m_hused) begin
            m_ack   = 1'b1;
            m_hused = 1'b1;
            if (m_hold == '0) begin
               m_spawn = m_q.pop_front();
               m_phase = 0;
            end else begin
               m_spawn = m_hold;
            end
            m_hold = game_if.active_piece;
         end
      end
   end

   function automatic logic [DEPTH*PW-1:0] pack_q(input logic [PW-1:0] q [$]);
      logic [DEPTH*PW-1:0] v;
      v = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i < q.size()) v[i*PW +: PW] = q[i];
      end
      return v;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      cmp(name, act, exp);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (m_started) begin
         vectors++;
         cmp("rand_req",    32'(rand_req),            32'(m_rreq));
         cmp("ready",       32'(game_if.ready),       32'(m_ready));
         cmp("spawn_ack",   32'(game_if.spawn_ack),   32'(m_ack));
         cmp("spawn_piece", 32'(game_if.spawn_piece), 32'(m_spawn));
         cmp("hold_piece",  32'(game_if.hold_piece),  32'(m_hold));
         cmp("hold_used",   32'(game_if.hold_used),   32'(m_hused));
         cmp("preview",     32'(game_if.preview),     32'(pack_q(m_q)));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic sel(input int which);
      case (which)
         0:       return game_if.spawn_ack;
         1:       return game_if.ready;
         default: return rand_req;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input logic val, input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (sel(which) === val) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no event within %0d cycles, expected value %0b", name, limit, val);
      end
   endtask

   task automatic refill_wait(input string name);
      wait_for({name, "_rdy_low"}, 1, 1'b0, 4);
      wait_for({name, "_rdy_high"}, 1, 1'b1, 16);
   endtask

   initial begin
      logic [9:0] rq_pat, rdy_pat;
      int acks, hits, cyc, hold_wait, r;

      game_if.spawn_req    = 1'b0;
      game_if.hold_req     = 1'b0;
      game_if.active_piece = '0;

      // Reset state
      repeat (3) tick();
      check("rst_ready",   32'(game_if.ready),      32'd0);
      check("rst_randreq", 32'(rand_req),           32'd0);
      check("rst_hold",    32'(game_if.hold_piece), 32'd0);
      check("rst_preview", 32'(game_if.preview),    32'd0);

      // Fill from reset with 5, 2, 7
      seq = '{3'd5, 3'd2, 3'd7};
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         rq_pat[k]  = rand_req;
         rdy_pat[k] = game_if.ready;
      end
      check("fill_rreq_pattern",  32'(rq_pat),          32'h049);
      check("fill_ready_pattern", 32'(rdy_pat),         32'h200);
      check("fill_preview",       32'(game_if.preview), 32'({3'd7, 3'd2, 3'd5}));

      // Spawn, refill with 4
      seq.push_back(3'd4);
      game_if.spawn_req = 1'b1;
      wait_for("spawn_ack", 0, 1'b1, 6);
      check("spawn_piece", 32'(game_if.spawn_piece), 32'd5);
      game_if.spawn_req = 1'b0;
      refill_wait("spawn_refill");
      check("spawn_preview", 32'(game_if.preview), 32'({3'd4, 3'd7, 3'd2}));

      // Hold into the empty slot, refill with 1
      seq.push_back(3'd1);
      game_if.active_piece = 3'd6;
      game_if.hold_req     = 1'b1;
      wait_for("hold_ack", 0, 1'b1, 6);
      check("hold_spawn", 32'(game_if.spawn_piece), 32'd2);
      check("hold_piece", 32'(game_if.hold_piece),  32'd6);
      check("hold_used",  32'(game_if.hold_used),   32'd1);
      game_if.hold_req = 1'b0;
      refill_wait("hold_refill");
      check("hold_preview", 32'(game_if.preview), 32'({3'd1, 3'd4, 3'd7}));

      // Second hold for the same piece is ignored
      game_if.hold_req = 1'b1;
      acks = 0;
      repeat (6) begin
         tick();
         if (game_if.spawn_ack) acks++;
      end
      game_if.hold_req = 1'b0;
      check("rehold_acks", 32'(acks),               32'd0);
      check("rehold_hold", 32'(game_if.hold_piece), 32'd6);

      // Spawn clears hold_used, then swap with the full hold slot
      seq.push_back(3'd5);
      game_if.spawn_req = 1'b1;
      wait_for("spawn2_ack", 0, 1'b1, 6);
      check("spawn2_piece", 32'(game_if.spawn_piece), 32'd7);
      check("spawn2_hused", 32'(game_if.hold_used),   32'd0);
      game_if.spawn_req = 1'b0;
      refill_wait("spawn2_refill");
      game_if.active_piece = 3'd3;
      game_if.hold_req     = 1'b1;
      wait_for("swap_ack", 0, 1'b1, 6);
      check("swap_spawn", 32'(game_if.spawn_piece), 32'd6);
      check("swap_hold",  32'(game_if.hold_piece),  32'd3);
      game_if.hold_req = 1'b0;
      hits = 0;
      repeat (4) begin
         tick();
         if (rand_req || !game_if.ready) hits++;
      end
      check("swap_no_refill", 32'(hits),            32'd0);
      check("swap_preview",   32'(game_if.preview), 32'({3'd5, 3'd1, 3'd4}));

      // Randomizer returns 0 once: one extra fetch
      rst = 1'b1;
      repeat (2) tick();
      seq.delete();
      seq = '{3'd0, 3'd1, 3'd2, 3'd3};
      rst = 1'b0;
      cyc = -1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (game_if.ready) begin
            cyc = k;
            break;
         end
      end
      check("zero_fill_cycle", 32'(cyc),             32'd12);
      check("zero_preview",    32'(game_if.preview), 32'({3'd3, 3'd2, 3'd1}));

      // Reset during the FETCH_WAIT cycle of a refill
      game_if.active_piece = 3'd5;
      game_if.hold_req     = 1'b1;
      wait_for("mid_hold_ack", 0, 1'b1, 6);
      game_if.hold_req = 1'b0;
      check("mid_hold_piece", 32'(game_if.hold_piece), 32'd5);
      seq = '{3'd4, 3'd6, 3'd7, 3'd2};
      wait_for("mid_rreq", 2, 1'b1, 4);
      rst = 1'b1;
      tick();
      check("mid_rst_hold",    32'(game_if.hold_piece),  32'd0);
      check("mid_rst_ready",   32'(game_if.ready),       32'd0);
      check("mid_rst_preview", 32'(game_if.preview),     32'd0);
      check("mid_rst_spawn",   32'(game_if.spawn_piece), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         rq_pat[k]  = rand_req;
         rdy_pat[k] = game_if.ready;
      end
      check("mid_rreq_pattern",  32'(rq_pat),          32'h049);
      check("mid_ready_pattern", 32'(rdy_pat),         32'h200);
      check("mid_preview",       32'(game_if.preview), 32'({3'd2, 3'd7, 3'd6}));

      // Randomized game-FSM traffic
      hold_wait = 0;
      for (int n = 0; n < 4000; n++) begin
         tick();
         if (rst) begin
            rst = 1'b0;
         end else if ($urandom_range(0, 399) == 0) begin
            rst = 1'b1;
            game_if.spawn_req = 1'b0;
            game_if.hold_req  = 1'b0;
         end else if (game_if.spawn_req || game_if.hold_req) begin
            hold_wait++;
            if (game_if.spawn_ack) begin
               game_if.spawn_req = 1'b0;
               game_if.hold_req  = 1'b0;
            end else if (!game_if.spawn_req && hold_wait > 4 && game_if.hold_used) begin
               game_if.hold_req = 1'b0;
            end
         end else begin
            r = $urandom_range(0, 9);
            hold_wait = 0;
            game_if.active_piece = PW'($urandom_range(1, 7));
            if (r < 3) begin
               game_if.spawn_req = 1'b1;
               game_if.hold_req  = ($urandom_range(0, 3) == 0);
            end else if (r < 5) begin
               game_if.hold_req = 1'b1;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
